// File: rtl/ntt_stream_fifo.sv
// First-word-fall-through stream FIFO carrying 65-bit {eot, coefficient} words between NTT stages.
// Latency: a written word is visible on dout/peek one edge later; a pop exposes the next head immediately.
// Backpressure: full_n drops at DEPTH entries, and a write while full is dropped even if a pop is accepted in the same cycle.
module ntt_stream_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] if_din,
    input  logic             if_write,
    output logic             if_full_n,
    output logic [WIDTH-1:0] if_dout,
    output logic             if_empty_n,
    input  logic             if_read,
    output logic [WIDTH-1:0] if_peek,
    output logic [AW:0]      if_count,
    output logic             if_eot_seen
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             eot_seen;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] head;

    // Status is decoded from registered occupancy only, so the request inputs never reach an output.
    assign if_full_n  = (cnt != CNT_FULL);
    assign if_empty_n = (cnt != '0);
    assign if_count   = cnt;
    assign if_eot_seen = eot_seen;

    assign wr_acc = if_write && if_full_n;
    assign rd_acc = if_read  && if_empty_n;

    always_comb begin
        head = '0;
        if (if_empty_n) begin
            head = mem[rp];
        end
    end

    assign if_dout = head;
    assign if_peek = head;

    // Storage is not reset; stale entries are masked by empty_n and the pointers.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wp] <= if_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            eot_seen <= 1'b0;
        end else begin
            if (wr_acc) begin
                wp <= wp + AW'(1);
                if (if_din[WIDTH-1]) begin
                    eot_seen <= 1'b1;
                end
            end
            if (rd_acc) begin
                rp <= rp + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_stream_fifo.sv
// Directed bench for ntt_stream_fifo: a queue scoreboard predicts every accepted word and occupancy.
module tb_ntt_stream_fifo;

    localparam int W = 65;
    localparam int D = 16;

    logic         clk;
    logic         reset;
    logic [W-1:0] if_din;
    logic         if_write;
    logic         if_full_n;
    logic [W-1:0] if_dout;
    logic         if_empty_n;
    logic         if_read;
    logic [W-1:0] if_peek;
    logic [4:0]   if_count;
    logic         if_eot_seen;

    ntt_stream_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_din     (if_din),
        .if_write   (if_write),
        .if_full_n  (if_full_n),
        .if_dout    (if_dout),
        .if_empty_n (if_empty_n),
        .if_read    (if_read),
        .if_peek    (if_peek),
        .if_count   (if_count),
        .if_eot_seen(if_eot_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] sb_q[$];
    int           m_cnt;
    logic         m_eot;
    int           n_checks;
    int           n_fail;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        logic [W-1:0] exp_head;
        exp_head = (sb_q.size() != 0) ? sb_q[0] : '0;
        check("count",    W'(if_count),    W'(m_cnt));
        check("full_n",   W'(if_full_n),   W'(m_cnt != D));
        check("empty_n",  W'(if_empty_n),  W'(m_cnt != 0));
        check("eot_seen", W'(if_eot_seen), W'(m_eot));
        check("dout",     if_dout,         exp_head);
        check("peek",     if_peek,         exp_head);
    endtask

    task automatic do_reset(input logic w, input logic [W-1:0] d);
        reset    = 1'b1;
        if_write = w;
        if_din   = d;
        if_read  = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        m_cnt = 0;
        m_eot = 1'b0;
        check_status();
        reset    = 1'b0;
        if_write = 1'b0;
    endtask

    task automatic cycle(input logic w, input logic [W-1:0] d, input logic r);
        logic         wa;
        logic         ra;
        logic [W-1:0] exp;
        if_write = w;
        if_din   = d;
        if_read  = r;
        wa = w && (m_cnt != D);
        ra = r && (m_cnt != 0);
        if (ra) begin
            exp = sb_q.pop_front();
            check("pop_dout", if_dout, exp);
        end
        if (wa) begin
            sb_q.push_back(d);
            if (d[W-1]) m_eot = 1'b1;
        end
        m_cnt = m_cnt + int'(wa) - int'(ra);
        @(posedge clk);
        #1;
        if_write = 1'b0;
        if_read  = 1'b0;
        check_status();
    endtask

    task automatic drain_all();
        for (int i = 0; i < D + 2 && m_cnt != 0; i++) cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_cnt    = 0;
        m_eot    = 1'b0;
        reset    = 1'b1;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;

        // reset, then first word visible one edge later
        do_reset(1'b0, '0);
        cycle(1'b1, W'(1), 1'b0);
        drain_all();

        // fill to full, 17th write dropped, drain in order, then read on empty ignored
        for (int i = 1; i <= 17; i++) cycle(1'b1, W'(i), 1'b0);
        drain_all();
        cycle(1'b0, '0, 1'b1);

        // simultaneous read+write at cnt=5
        for (int i = 0; i < 5; i++) cycle(1'b1, W'(32'h100 + i), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(32'h200 + i), 1'b1);
        drain_all();

        // simultaneous at full: read wins, write rejected
        for (int i = 0; i < D; i++) cycle(1'b1, W'(32'h300 + i), 1'b0);
        cycle(1'b1, W'(32'hDEAD), 1'b1);
        drain_all();

        // simultaneous at empty: write wins, read rejected
        cycle(1'b1, W'(32'h77), 1'b1);
        drain_all();

        // wraparound streaming at constant occupancy 3
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(32'h400 + i), 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, {1'b0, 32'($urandom), 32'($urandom)}, 1'b1);
        drain_all();

        // EOT word: flag sticky, bit 64 carried through
        cycle(1'b1, {1'b1, 64'h0}, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // reset mid-stream at cnt=7 with a write held high
        cycle(1'b1, {1'b1, 64'h55}, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, W'(32'h500 + i), 1'b0);
        do_reset(1'b1, W'(32'hAAAA));
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, W'(32'h600), 1'b0);
        drain_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
